// File: rtl/pio_out_pulse.sv
// Memory-mapped parallel output port with an optional timed pulse (bit invert) feature.
// The pulse feature is built only when PIO_OUT_PULSE_EN is defined.
module pio_out_pulse #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PLEN   = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLEAR  = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam logic [WIDTH-1:0] DATA_RST = RESET_VALUE[WIDTH-1:0];

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wd           = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:  data_d = wd;
                ADDR_SET:   data_d = data_q | wd;
                ADDR_CLEAR: data_d = data_q & ~wd;
                default:    data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= DATA_RST;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef PIO_OUT_PULSE_EN
    logic [CNT_W-1:0] plen_q, plen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] plen_eff;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q;
    logic             pulse_wr, status_wr, expire;

    assign pulse_wr  = wr && (address == ADDR_PULSE);
    assign status_wr = wr && (address == ADDR_STATUS);
    assign plen_eff  = (plen_q == '0) ? CNT_W'(1) : plen_q;
    // Last busy cycle: the counter steps from 1 to 0 on this edge.
    assign expire    = busy_q && (cnt_q == CNT_W'(1));

    always_comb begin
        plen_d   = plen_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        busy_d   = busy_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;

        if (wr && (address == ADDR_PLEN)) begin
            plen_d = writedata[CNT_W-1:0];
        end

        if (status_wr) begin
            irq_en_d = writedata[2];
            if (writedata[1]) begin
                done_d = 1'b0;
            end
        end

        // A pulse write on the expiry edge restarts with a fresh mask and suppresses done.
        if (pulse_wr) begin
            mask_d = (expire ? '0 : mask_q) | wd;
            cnt_d  = plen_eff;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (expire) begin
                mask_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plen_q   <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            plen_q   <= plen_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end

    always_comb begin
        readdata = 32'h0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_PLEN:   readdata = 32'(plen_q);
            ADDR_STATUS: readdata = {29'h0, irq_en_q, done_q, busy_q};
            default:     readdata = 32'h0;
        endcase
    end

    assign out_port = busy_q ? (data_q ^ mask_q) : data_q;
    assign irq      = irq_q;
`else
    logic [CNT_W-1:0] unused_plen;

    assign unused_plen = writedata[CNT_W-1:0];

    always_comb begin
        readdata = 32'h0;
        if (address == ADDR_DATA) begin
            readdata = 32'(data_q);
        end
    end

    assign out_port = data_q;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_pio_out_pulse.sv
// Randomized self-checking bench for pio_out_pulse against a cycle-indexed behavioural model.
// Exercises the pulse feature when PIO_OUT_PULSE_EN is defined, the plain port otherwise.
module tb_pio_out_pulse;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;
    localparam logic [31:0] RV = 32'h0000_005A;
`ifdef PIO_OUT_PULSE_EN
    localparam bit PulseEn = 1'b1;
`else
    localparam bit PulseEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;
    logic          irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: pulse is active for edges k with start <= k < m_end.
    logic [W-1:0] m_data, m_mask;
    int           m_plen, m_end;
    bit           m_active, m_done, m_irq_en;

    pio_out_pulse #(
        .WIDTH      (W),
        .RESET_VALUE(RV),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return PulseEn ? 32'(m_plen) : 32'h0;
            3'd5:    return PulseEn ? {29'h0, m_irq_en, m_done, m_active} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [W-1:0] model_out();
        return m_active ? (m_data ^ m_mask) : m_data;
    endfunction

    task automatic model_reset();
        m_data   = RV[W-1:0];
        m_mask   = '0;
        m_plen   = 0;
        m_end    = 0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_irq_en = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input logic [2:0] a, input logic [31:0] wd);
        bit expiring;
        int len;
        expiring = m_active && (cyc == m_end);
        if (wr && a == 3'd0) m_data = wd[W-1:0];
        if (wr && a == 3'd2) m_data = m_data | wd[W-1:0];
        if (wr && a == 3'd3) m_data = m_data & ~wd[W-1:0];
        if (PulseEn) begin
            len = (m_plen == 0) ? 1 : m_plen;
            if (wr && a == 3'd4) begin
                m_mask   = ((m_active && !expiring) ? m_mask : '0) | wd[W-1:0];
                m_end    = cyc + len;
                m_active = 1'b1;
            end else if (expiring) begin
                m_active = 1'b0;
                m_mask   = '0;
            end
            if (wr && a == 3'd5) begin
                m_irq_en = wd[2];
                if (wd[1]) m_done = 1'b0;
            end
            if (expiring && !(wr && a == 3'd4)) m_done = 1'b1;
            if (wr && a == 3'd1) m_plen = int'(wd & ((32'h1 << CW) - 1));
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        #1;
        check_eq("readdata", readdata, model_read(a));
        @(posedge clk);
        #1;
        cyc++;
        model_edge(cs && !wn, a, wd);
        check_eq("out_port", 32'(out_port), 32'(model_out()));
        check_eq("irq", 32'(irq), 32'(m_done & m_irq_en));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        cycle(1'b1, 1'b0, a, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cycle(1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic do_reset();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd5;
        reset_n    = 1'b0;
        #1;
        model_reset();
        check_eq("rst_out_port", 32'(out_port), 32'(RV[W-1:0]));
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_status", readdata, 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state and basic DATA/SET/CLEAR.
        #1;
        check_eq("rst_read_data", readdata, 32'(RV[W-1:0]));
        check_eq("rst_out", 32'(out_port), 32'(RV[W-1:0]));
        check_eq("rst_irq0", 32'(irq), 32'h0);
        rd_reg(3'd0);
        wr_reg(3'd0, 32'h0000_000F);
        check_eq("d_data", 32'(out_port), 32'h0F);
        wr_reg(3'd2, 32'h0000_0030);
        check_eq("d_set", 32'(out_port), 32'h3F);
        wr_reg(3'd3, 32'h0000_0003);
        check_eq("d_clear", 32'(out_port), 32'h3C);
        rd_reg(3'd0);
        check_eq("d_read", readdata, 32'h3C);

`ifdef PIO_OUT_PULSE_EN
        // Single pulse, PLEN=4.
        wr_reg(3'd1, 32'd4);
        wr_reg(3'd0, 32'h0);
        wr_reg(3'd4, 32'h81);
        check_eq("p1_first", 32'(out_port), 32'h81);
        repeat (3) begin
            idle();
            check_eq("p1_hold", 32'(out_port), 32'h81);
        end
        idle();
        check_eq("p1_end", 32'(out_port), 32'h00);
        rd_reg(3'd5);
        check_eq("p1_status", readdata, 32'h2);
        wr_reg(3'd5, 32'h2);

        // Extended pulse.
        wr_reg(3'd4, 32'h01);
        check_eq("p2_a", 32'(out_port), 32'h01);
        idle();
        check_eq("p2_b", 32'(out_port), 32'h01);
        wr_reg(3'd4, 32'h02);
        check_eq("p2_ext", 32'(out_port), 32'h03);
        repeat (3) begin
            idle();
            check_eq("p2_hold", 32'(out_port), 32'h03);
        end
        idle();
        check_eq("p2_end", 32'(out_port), 32'h00);
        rd_reg(3'd5);
        check_eq("p2_status", readdata, 32'h2);
        wr_reg(3'd5, 32'h2);

        // PULSE on the expiry edge, and PLEN=0 behaving as 1.
        wr_reg(3'd1, 32'd2);
        wr_reg(3'd4, 32'h01);
        idle();
        wr_reg(3'd4, 32'h04);
        check_eq("p3_collide", 32'(out_port), 32'h04);
        rd_reg(3'd5);
        check_eq("p3_status", readdata, 32'h1);
        idle();
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd4, 32'h00);
        idle();
        check_eq("p4_zero_done", 32'(dut.readdata), model_read(3'd0));
        rd_reg(3'd5);
        check_eq("p4_status", readdata, 32'h2);

        // Interrupt, clear, and reset mid-pulse.
        wr_reg(3'd5, 32'h4);
        check_eq("irq_on", 32'(irq), 32'h1);
        wr_reg(3'd5, 32'h6);
        check_eq("irq_off", 32'(irq), 32'h0);
        wr_reg(3'd1, 32'd5);
        wr_reg(3'd0, 32'h0F);
        wr_reg(3'd4, 32'hF0);
        idle();
        check_eq("mid_pulse", 32'(out_port), 32'hFF);
        do_reset();
        rd_reg(3'd5);
        check_eq("after_rst_status", readdata, 32'h0);
`else
        wr_reg(3'd4, 32'hFF);
        check_eq("nopulse_out", 32'(out_port), 32'h3C);
        check_eq("nopulse_irq", 32'(irq), 32'h0);
        wr_reg(3'd1, 32'd7);
        rd_reg(3'd1);
        check_eq("nopulse_plen", readdata, 32'h0);
        rd_reg(3'd5);
        check_eq("nopulse_status", readdata, 32'h0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      3'($urandom_range(0, 7)), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
